// File: rtl/queue_write_arbiter_pkg.sv
// Shared definitions for the queue write arbiter: FSM encoding, default limits
// and the debug view of the arbiter state.
package queue_write_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 2;
    localparam int MAX_NUM_REQ   = 8;

    // Fixed-width fields so the debug view does not depend on parameters.
    typedef struct packed {
        arb_state_t  state;
        logic [2:0]  rr_ptr;
        logic [2:0]  owner;
        logic [7:0]  burst_cnt;
    } arb_dbg_t;

endpackage

// File: rtl/rr_priority_select.sv
// Circular first-one search: finds the first set req bit starting at ptr and
// wrapping past NumReq-1 back to 0.
module rr_priority_select #(
    parameter int NumReq = 4,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic              any,
    output logic [PtrW-1:0]   sel
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int idx;
        any = |req;
        sel = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (req[idx]) sel = PtrW'(idx);
        end
    end

endmodule

// File: rtl/queue_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one Queue write port among NumReq
// producers, tracking queue occupancy and gating the consumer pull.
module queue_write_arbiter
    import queue_write_arbiter_pkg::*;
#(
    parameter int Width        = 8,
    parameter int AddressWidth = 2,
    parameter int NumReq       = DEF_NUM_REQ,
    parameter int MaxBurst     = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumReq-1:0]        req,
    input  logic [NumReq*Width-1:0]  req_data,
    output logic [NumReq-1:0]        ack,
    input  logic                     rd_req,
    output logic                     q_push,
    output logic [Width-1:0]         q_D,
    output logic                     q_pull,
    output logic [AddressWidth:0]    count,
    output logic                     empty,
    output logic                     full,
    output arb_dbg_t                 dbg
);

    localparam int PtrW  = $clog2(NumReq);
    localparam int BW    = $clog2(MaxBurst + 1);
    localparam int CW    = AddressWidth + 1;
    localparam int Depth = 1 << AddressWidth;

    arb_state_t        state, state_next;
    logic [PtrW-1:0]   rr_ptr, rr_ptr_next;
    logic [PtrW-1:0]   owner, owner_next;
    logic [BW-1:0]     burst_cnt, burst_cnt_next;
    logic [CW-1:0]     count_next;

    logic              search;
    logic [PtrW-1:0]   search_ptr;
    logic              sel_any;
    logic [PtrW-1:0]   sel;
    logic [PtrW-1:0]   grant_idx;
    logic              push_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(NumReq - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CW'(Depth));
    assign empty   = (count == '0);
    assign q_pull  = rd_req & ~empty;
    assign push_ok = ~full | q_pull;

    // An owner that dropped req is released this cycle and the search starts
    // just past it, so another requester can take the slot immediately.
    assign search     = (state == ARB_IDLE) || !req[owner];
    assign search_ptr = (state == ARB_OWN) ? ptr_inc(owner) : rr_ptr;

    rr_priority_select #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_sel (
        .req (req),
        .ptr (search_ptr),
        .any (sel_any),
        .sel (sel)
    );

    // req[i]/ack[i] form a valid/ready pair: req holds with stable data until
    // ack, and the word is pushed into the queue in the same cycle ack is high.
    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        owner_next     = owner;
        burst_cnt_next = burst_cnt;
        grant_idx      = owner;
        q_push         = 1'b0;

        if (search) begin
            if (state == ARB_OWN) begin
                state_next  = ARB_IDLE;
                rr_ptr_next = ptr_inc(owner);
            end
            if (sel_any && push_ok) begin
                grant_idx      = sel;
                q_push         = 1'b1;
                owner_next     = sel;
                burst_cnt_next = BW'(1);
                if (MaxBurst == 1) begin
                    state_next  = ARB_IDLE;
                    rr_ptr_next = ptr_inc(sel);
                end else begin
                    state_next  = ARB_OWN;
                end
            end
        end else if (push_ok) begin
            q_push         = 1'b1;
            burst_cnt_next = burst_cnt + BW'(1);
            if (burst_cnt_next == BW'(MaxBurst)) begin
                state_next  = ARB_IDLE;
                rr_ptr_next = ptr_inc(owner);
            end
        end
    end

    always_comb begin
        ack = '0;
        q_D = '0;
        if (q_push) begin
            ack[grant_idx] = 1'b1;
            q_D            = req_data[int'(grant_idx)*Width +: Width];
        end
    end

    assign count_next = count + CW'(q_push) - CW'(q_pull);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            owner     <= owner_next;
            burst_cnt <= burst_cnt_next;
            count     <= count_next;
        end
    end

    always_comb begin
        dbg           = '0;
        dbg.state     = state;
        dbg.rr_ptr    = 3'(rr_ptr);
        dbg.owner     = 3'(owner);
        dbg.burst_cnt = 8'(burst_cnt);
    end

endmodule
